reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 16, number of architectural registers (r15 = ra).
REQ-002 SHALL have parameter CNT_W, default 2, width of per-register pending-write counter (max 3 in flight per register).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-004 SHALL have: issue_valid input 1, decode presents an instruction.
REQ-005 SHALL have: issue_ready output 1, instruction may issue this cycle.
REQ-006 SHALL have: rs1, rs2, rd input 4 each, source/destination register indices, already resolved for ret (rs1=15) and st (rs2=rd) by decode.
REQ-007 SHALL have: uses_rs1, uses_rs2, writes_rd input 1 each, operand/destination qualifiers.
REQ-008 SHALL have: wb_valid input 1 and wb_rd input 4, register-file write retiring this cycle.
REQ-009 SHALL have: flush input 1, branch taken; drain in-flight work.
REQ-010 SHALL have: busy_mask output NREG, bit i high when counter[i] != 0.
REQ-011 SHALL have: inflight output 6, total pending writes.
REQ-012 SHALL have: draining output 1, high in DRAIN state.
REQ-013 SHALL have: err_underflow output 1, sticky error flag.

Function
REQ-014 SHALL hold one CNT_W-bit counter per register and one 6-bit total counter inflight.
REQ-015 SHALL define fire = issue_valid & issue_ready.
REQ-016 SHALL compute issue_ready combinationally from registered state only: state==RUN, !(uses_rs1 & cnt[rs1]!=0), !(uses_rs2 & cnt[rs2]!=0), !(writes_rd & cnt[rd]==3).
REQ-017 SHALL NOT bypass: a writeback in the same cycle does not make a dependent instruction ready; it becomes ready the next cycle.
REQ-018 SHALL increment cnt[rd] and inflight on fire & writes_rd.
REQ-019 SHALL decrement cnt[wb_rd] and inflight on wb_valid when cnt[wb_rd]!=0.
REQ-020 SHALL leave cnt[x] and inflight unchanged when fire & writes_rd and wb_valid target the same register x in the same cycle.
REQ-021 SHALL ignore wb_valid to a register with cnt==0, leaving counters unchanged, and set err_underflow, which stays set until reset.
REQ-022 SHALL implement FSM states RUN and DRAIN.
REQ-023 SHALL transition RUN->DRAIN on flush when inflight!=0 or a write is issuing that cycle; otherwise remain in RUN.
REQ-024 SHALL hold issue_ready low in DRAIN, with counters still decrementing on writeback.
REQ-025 SHALL transition DRAIN->RUN in the cycle after inflight reaches 0.
REQ-026 SHALL ignore flush while already in DRAIN.
REQ-027 SHALL accept an issue in the flush cycle (RUN state) and count it, so that flush takes effect from the next cycle.
REQ-028 SHALL NOT wrap inflight: saturating counters cap it at NREG*3 = 48.

Reset
REQ-029 SHALL, on rst asserted asynchronously, clear all counters, set inflight=0, state=RUN and err_underflow=0.
REQ-030 SHALL drive, while in reset: busy_mask=0, inflight=0, draining=0 and issue_ready=0.
REQ-031 SHALL drive issue_ready per REQ-016 after rst deasserts; any mid-operation reset discards all pending state.

Structure
REQ-032 SHALL keep NREG, CNT_W, the RA index (15) and the FSM state enum in the shared processor package.
REQ-033 SHALL use one sub-module, sb_counter, a saturating up/down counter with simultaneous inc/dec, instantiated NREG times.

Verification
REQ-034 SHALL verify RAW stall: issue rd=3; next cycle issue rs1=3 -> issue_ready=0 until the cycle after wb_rd=3, then 1; busy_mask[3] 1->0.
REQ-035 SHALL verify same-cycle issue and writeback: cnt[5]=1, issue writes_rd rd=5 with wb_rd=5 -> cnt[5] stays 1, inflight unchanged.
REQ-036 SHALL verify saturation: three issues to rd=7 -> a fourth issue writing rd=7 sees issue_ready=0; an issue writing rd=8 sees issue_ready=1.
REQ-037 SHALL verify flush drain: inflight=2, flush -> draining=1 and issue_ready=0; after two writebacks inflight=0, then the next cycle draining=0.
REQ-038 SHALL verify underflow: wb_rd=9 with cnt[9]=0 -> counters unchanged, err_underflow=1 until rst.
REQ-039 SHALL verify mid-drain reset: rst during DRAIN with inflight=3 -> all outputs at reset values immediately; after release, an issue using rs1=15 is ready.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared register-file sizing, return-address index and scoreboard FSM states
package reg_scoreboard_pkg;
  localparam int NREG = 16;
  localparam int CNT_W = 2;
  localparam int RA = 15;
  localparam int IF_W = 6;
  typedef enum logic {RUN, DRAIN} state_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: issue, writeback, flush and status signals between decode and scoreboard
interface reg_scoreboard_if import reg_scoreboard_pkg::*; #(parameter int N = NREG);
  localparam int IW = $clog2(N);
  logic issue_valid;
  logic issue_ready;
  logic [IW-1:0] rs1;
  logic [IW-1:0] rs2;
  logic [IW-1:0] rd;
  logic uses_rs1;
  logic uses_rs2;
  logic writes_rd;
  logic wb_valid;
  logic [IW-1:0] wb_rd;
  logic flush;
  logic [N-1:0] busy_mask;
  logic [IF_W-1:0] inflight;
  logic draining;
  logic err_underflow;
  modport master(
    output issue_valid, rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, wb_valid, wb_rd, flush,
    input issue_ready, busy_mask, inflight, draining, err_underflow
  );
  modport slave(
    input issue_valid, rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, wb_valid, wb_rd, flush,
    output issue_ready, busy_mask, inflight, draining, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: saturating up/down counter; simultaneous inc and dec cancel out
module sb_counter #(parameter int W = 2) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (i_inc & ~i_dec & (r_cnt != '1)) r_cnt <= r_cnt + W'(1);
    else if (i_dec & ~i_inc & (r_cnt != '0)) r_cnt <= r_cnt - W'(1);
  end
  assign o_cnt = r_cnt;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracking with RAW/WAW-depth issue gating and flush drain
module reg_scoreboard import reg_scoreboard_pkg::*; #(
  parameter int NREG = reg_scoreboard_pkg::NREG,
  parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
  input logic clk,
  input logic rst,
  reg_scoreboard_if.slave sb
);
  localparam int IW = $clog2(NREG);
  localparam int CMAX = 2**CNT_W - 1;
  localparam int IF_MAX = NREG * CMAX;
  state_t r_state, w_next;
  logic [IF_W-1:0] r_inflight;
  logic r_err;
  logic [CNT_W-1:0] w_cnt [NREG];
  logic [NREG-1:0] w_inc, w_dec, w_busy;
  logic w_ready, w_wr, w_wb;
  assign w_ready = ~rst & (r_state == RUN)
    & ~(sb.uses_rs1 & (w_cnt[sb.rs1] != '0))
    & ~(sb.uses_rs2 & (w_cnt[sb.rs2] != '0))
    & ~(sb.writes_rd & (w_cnt[sb.rd] == CNT_W'(CMAX)));
  assign w_wr = sb.issue_valid & w_ready & sb.writes_rd;
  // writebacks to an idle register are dropped and only flag the error
  assign w_wb = sb.wb_valid & (w_cnt[sb.wb_rd] != '0);
  for (genvar i = 0; i < NREG; i++) begin : g_cnt
    assign w_inc[i] = w_wr & (sb.rd == IW'(i));
    assign w_dec[i] = w_wb & (sb.wb_rd == IW'(i));
    assign w_busy[i] = w_cnt[i] != '0;
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .i_inc(w_inc[i]), .i_dec(w_dec[i]), .o_cnt(w_cnt[i])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_inflight <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err <= r_err | (sb.wb_valid & ~w_wb);
      if (w_wr & ~w_wb & (r_inflight != IF_W'(IF_MAX))) r_inflight <= r_inflight + IF_W'(1);
      else if (w_wb & ~w_wr & (r_inflight != '0)) r_inflight <= r_inflight - IF_W'(1);
    end
  end
  always_comb begin
    w_next = r_state;
    sb.draining = r_state == DRAIN;
    w_next = (r_state == RUN) ? ((sb.flush & ((r_inflight != '0) | w_wr)) ? DRAIN : RUN)
                              : ((r_inflight == '0) ? RUN : DRAIN);
  end
  assign sb.issue_ready = w_ready;
  assign sb.busy_mask = w_busy;
  assign sb.inflight = r_inflight;
  assign sb.err_underflow = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed scenarios plus random traffic against a counting reference model
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;
  typedef struct packed {
    logic [15:0] busy;
    logic [5:0]  inf;
    logic        dr;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  reg_scoreboard_if sb();
  reg_scoreboard dut (.clk(clk), .rst(rst), .sb(sb));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int m_cnt[16];
  bit m_drain, m_err;
  logic last_ready;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int m_inf();
    int s = 0;
    for (int i = 0; i < 16; i++) s += m_cnt[i];
    return s;
  endfunction
  function automatic logic [15:0] m_busy();
    logic [15:0] b = '0;
    for (int i = 0; i < 16; i++) b[i] = m_cnt[i] != 0;
    return b;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_drain = 0;
    m_err = 0;
  endtask
  task automatic cyc(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                     input int d, input bit w, input bit wv, input int wr, input bit fl);
    bit rdy, fire, wok;
    int inf0;
    exp_t e;
    sb.issue_valid = v; sb.rs1 = 4'(r1); sb.uses_rs1 = u1; sb.rs2 = 4'(r2); sb.uses_rs2 = u2;
    sb.rd = 4'(d); sb.writes_rd = w; sb.wb_valid = wv; sb.wb_rd = 4'(wr); sb.flush = fl;
    #1;
    rdy = !m_drain && !(u1 && m_cnt[r1] != 0) && !(u2 && m_cnt[r2] != 0) && !(w && m_cnt[d] == 3);
    last_ready = sb.issue_ready;
    check("issue_ready", {31'd0, sb.issue_ready}, {31'd0, rdy});
    fire = v && rdy;
    inf0 = m_inf();
    wok = wv && m_cnt[wr] != 0;
    if (wv && !wok) m_err = 1;
    if (!(fire && w && wok && d == wr)) begin
      if (fire && w && m_cnt[d] < 3) m_cnt[d]++;
      if (wok) m_cnt[wr]--;
    end
    m_drain = m_drain ? (inf0 != 0) : (fl && (inf0 != 0 || (fire && w)));
    e = {m_busy(), 6'(m_inf()), m_drain, m_err};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("busy_mask", {16'd0, sb.busy_mask}, {16'd0, e.busy});
    check("inflight", {26'd0, sb.inflight}, {26'd0, e.inf});
    check("draining", {31'd0, sb.draining}, {31'd0, e.dr});
    check("err_underflow", {31'd0, sb.err_underflow}, {31'd0, e.err});
    @(negedge clk);
  endtask
  task automatic iss(input int d); cyc(1, 0, 0, 0, 0, d, 1, 0, 0, 0); endtask
  task automatic wb(input int r); cyc(0, 0, 0, 0, 0, 0, 0, 1, r, 0); endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic chk_reset(input string tag);
    check({tag, "_ready"}, {31'd0, sb.issue_ready}, 0);
    check({tag, "_busy"}, {16'd0, sb.busy_mask}, 0);
    check({tag, "_inflight"}, {26'd0, sb.inflight}, 0);
    check({tag, "_draining"}, {31'd0, sb.draining}, 0);
    check({tag, "_err"}, {31'd0, sb.err_underflow}, 0);
  endtask
  initial begin
    m_reset();
    sb.issue_valid = 0; sb.rs1 = 0; sb.rs2 = 0; sb.rd = 0; sb.uses_rs1 = 0; sb.uses_rs2 = 0;
    sb.writes_rd = 0; sb.wb_valid = 0; sb.wb_rd = 0; sb.flush = 0;
    #2 rst = 1;
    #1 chk_reset("reset");
    @(negedge clk);
    rst = 0;
    iss(3);
    check("raw_busy3_set", {31'd0, sb.busy_mask[3]}, 1);
    cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    check("raw_stall", {31'd0, last_ready}, 0);
    cyc(1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
    check("raw_no_bypass", {31'd0, last_ready}, 0);
    check("raw_busy3_clear", {31'd0, sb.busy_mask[3]}, 0);
    cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    check("raw_release", {31'd0, last_ready}, 1);
    iss(5);
    cyc(1, 0, 0, 0, 0, 5, 1, 1, 5, 0);
    check("same_cycle_inflight", {26'd0, sb.inflight}, 1);
    check("same_cycle_busy5", {31'd0, sb.busy_mask[5]}, 1);
    wb(5);
    iss(7); iss(7); iss(7);
    iss(7);
    check("sat_rd7_blocked", {31'd0, last_ready}, 0);
    iss(8);
    check("sat_rd8_ready", {31'd0, last_ready}, 1);
    check("sat_inflight", {26'd0, sb.inflight}, 4);
    wb(7); wb(7); wb(7); wb(8);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("flush_idle_run", {31'd0, sb.draining}, 0);
    iss(1); iss(2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("drain_enter", {31'd0, sb.draining}, 1);
    cyc(1, 0, 0, 0, 0, 6, 1, 0, 0, 1);
    check("drain_ready_low", {31'd0, last_ready}, 0);
    wb(1); wb(2);
    check("drain_inflight0", {26'd0, sb.inflight}, 0);
    check("drain_still", {31'd0, sb.draining}, 1);
    idle();
    check("drain_exit", {31'd0, sb.draining}, 0);
    cyc(1, 0, 0, 0, 0, 4, 1, 0, 0, 1);
    check("flush_cycle_issue", {26'd0, sb.inflight}, 1);
    check("flush_cycle_drain", {31'd0, sb.draining}, 1);
    wb(4); idle();
    wb(9);
    check("underflow_err", {31'd0, sb.err_underflow}, 1);
    check("underflow_inflight", {26'd0, sb.inflight}, 0);
    for (int n = 0; n < 150; n++)
      cyc($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15),
          $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 15), ($urandom_range(0, 15) == 0));
    check("underflow_sticky", {31'd0, sb.err_underflow}, 1);
    for (int r = 0; r < 16; r++) while (m_cnt[r] != 0) wb(r);
    idle();
    iss(1); iss(2); iss(3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("mid_drain_inflight", {26'd0, sb.inflight}, 3);
    check("mid_drain_state", {31'd0, sb.draining}, 1);
    #2 rst = 1;
    #1 chk_reset("mid_reset");
    m_reset();
    @(negedge clk);
    rst = 0;
    cyc(1, RA, 1, 0, 0, 0, 0, 0, 0, 0);
    check("ra_ready", {31'd0, last_ready}, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
